audio_sample_scheduler: RTL and testbench

Shares the single synchronous audio sample ROM port between the looping background-music (BGM) track and one active sound effect (SFX). On each codec sample request it fetches one BGM word, then one SFX word, mixes them with saturation and presents the result to the codec interface. It also gates codec start-up through the INIT / INIT_FINISH pair. It sits between the codec interface and the sample ROM.

---
 rtl/audio_sample_scheduler.sv | 154 +++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// Shares one synchronous sample-ROM port between looping BGM and one active SFX.
// Each codec request fetches BGM then SFX, mixes with saturation and presents the sample.
module audio_sample_scheduler #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned SFX_NUM   = 4,
  parameter int unsigned ROM_LAT   = 2,
  parameter int unsigned BGM_START = 0,
  parameter int unsigned BGM_END   = 109799,
  localparam int unsigned ID_W     = (SFX_NUM > 1) ? $clog2(SFX_NUM) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        INIT_FINISH,
  output logic                        INIT,
  input  logic                        data_over,
  input  logic                        bgm_en,
  input  logic [SFX_NUM-1:0]          sfx_trig,
  input  logic [SFX_NUM*ADDR_W-1:0]   sfx_base,
  input  logic [SFX_NUM*ADDR_W-1:0]   sfx_last,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic                        rom_rd,
  input  logic [SAMPLE_W-1:0]         rom_q,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        sample_valid,
  output logic                        sfx_busy,
  output logic [ID_W-1:0]             sfx_id,
  output logic                        overrun
);

  typedef enum logic [2:0] {
    S_WAIT_INIT, S_IDLE, S_RD_BGM, S_WAIT_BGM, S_RD_SFX, S_WAIT_SFX, S_MIX
  } state_t;

  localparam logic [ADDR_W-1:0] BGM_S = ADDR_W'(BGM_START);
  localparam logic [ADDR_W-1:0] BGM_E = ADDR_W'(BGM_END);
  localparam logic [1:0]        LAT_LAST = 2'(ROM_LAT - 1);

  state_t                state, state_n;
  logic [1:0]            lat_cnt;
  logic                  lat_done;
  logic [ADDR_W-1:0]     bgm_ptr, bgm_cur, sfx_ptr, sfx_last_sel, win_base;
  logic [ID_W-1:0]       win_id;
  logic [SFX_NUM-1:0]    pending;
  logic [SAMPLE_W-1:0]   bgm_reg, sfx_reg, bgm_term, mixed;
  logic [SAMPLE_W:0]     sum;

  assign INIT     = 1'b1;
  assign lat_done = (lat_cnt == LAT_LAST);
  assign bgm_cur  = (bgm_ptr > BGM_E) ? BGM_S : bgm_ptr;
  assign sfx_last_sel = sfx_last[int'(sfx_id) * ADDR_W +: ADDR_W];

  // Descending scan so the lowest pending index is the one left standing.
  always_comb begin
    win_id   = '0;
    win_base = '0;
    for (int unsigned i = SFX_NUM; i > 0; i--) begin
      if (pending[i-1]) begin
        win_id   = ID_W'(i - 1);
        win_base = sfx_base[(i-1)*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    bgm_term = bgm_en ? bgm_reg : '0;
    sum      = {bgm_term[SAMPLE_W-1], bgm_term} + {sfx_reg[SAMPLE_W-1], sfx_reg};
    mixed    = (sum[SAMPLE_W] != sum[SAMPLE_W-1])
             ? {sum[SAMPLE_W], {(SAMPLE_W-1){~sum[SAMPLE_W]}}}
             : sum[SAMPLE_W-1:0];
  end

  // With no effect playing the SFX read slot is skipped entirely.
  always_comb begin
    state_n  = state;
    rom_rd   = 1'b0;
    rom_addr = bgm_cur;
    case (state)
      S_WAIT_INIT: if (INIT_FINISH) state_n = S_IDLE;
      S_IDLE:      if (data_over) state_n = S_RD_BGM;
      S_RD_BGM: begin
        rom_rd  = 1'b1;
        state_n = S_WAIT_BGM;
      end
      S_WAIT_BGM:  if (lat_done) state_n = sfx_busy ? S_RD_SFX : S_MIX;
      S_RD_SFX: begin
        rom_rd   = 1'b1;
        rom_addr = sfx_ptr;
        state_n  = S_WAIT_SFX;
      end
      S_WAIT_SFX:  if (lat_done) state_n = S_MIX;
      S_MIX:       state_n = S_IDLE;
      default:     state_n = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_WAIT_INIT;
      lat_cnt      <= '0;
      bgm_ptr      <= BGM_S;
      sfx_ptr      <= '0;
      bgm_reg      <= '0;
      sfx_reg      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sfx_busy     <= 1'b0;
      sfx_id       <= '0;
      overrun      <= 1'b0;
      pending      <= '0;
    end else begin
      state        <= state_n;
      sample_valid <= 1'b0;

      if ((state == S_WAIT_BGM || state == S_WAIT_SFX) && !lat_done)
        lat_cnt <= lat_cnt + 2'd1;
      else
        lat_cnt <= '0;

      if (data_over && state != S_IDLE)
        overrun <= 1'b1;

      if (state == S_IDLE && |pending) begin
        sfx_ptr  <= win_base;
        sfx_id   <= win_id;
        sfx_busy <= 1'b1;
        pending  <= sfx_trig;
      end else if (state != S_WAIT_INIT) begin
        pending  <= pending | sfx_trig;
      end

      if (state == S_WAIT_BGM && lat_done) begin
        bgm_reg <= rom_q;
        if (!sfx_busy) sfx_reg <= '0;
      end

      if (state == S_WAIT_SFX && lat_done)
        sfx_reg <= rom_q;

      if (state == S_MIX) begin
        sample_out   <= mixed;
        sample_valid <= 1'b1;
        if (bgm_en)
          bgm_ptr <= (bgm_cur == BGM_E) ? BGM_S : bgm_cur + 1'b1;
        if (sfx_busy) begin
          sfx_ptr <= sfx_ptr + 1'b1;
          // ">=" also ends a degenerate range (last < base) after one word.
          if (sfx_ptr >= sfx_last_sel) sfx_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: driver queues expected samples and
// ROM addresses, a negedge monitor pops and compares when the DUT presents them.
module tb_audio_sample_scheduler;
  localparam int unsigned AW = 17, SW = 16, NS = 4, LAT = 2;

  logic            Clk = 1'b0;
  logic            Reset, INIT_FINISH, INIT, data_over, bgm_en;
  logic [NS-1:0]   sfx_trig;
  logic [NS*AW-1:0] sfx_base, sfx_last;
  logic [AW-1:0]   rom_addr;
  logic            rom_rd, sample_valid, sfx_busy, overrun;
  logic [SW-1:0]   rom_q, sample_out;
  logic [1:0]      sfx_id;

  always #5 Clk = ~Clk;

  audio_sample_scheduler #(
    .ADDR_W(AW), .SAMPLE_W(SW), .SFX_NUM(NS), .ROM_LAT(LAT),
    .BGM_START(0), .BGM_END(7)
  ) dut (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .INIT(INIT),
    .data_over(data_over), .bgm_en(bgm_en), .sfx_trig(sfx_trig),
    .sfx_base(sfx_base), .sfx_last(sfx_last), .rom_addr(rom_addr),
    .rom_rd(rom_rd), .rom_q(rom_q), .sample_out(sample_out),
    .sample_valid(sample_valid), .sfx_busy(sfx_busy), .sfx_id(sfx_id),
    .overrun(overrun)
  );

  // Two-stage synchronous ROM model (LAT = 2).
  logic [SW-1:0] mem [0:(1<<AW)-1];
  logic [SW-1:0] p1, p2;
  always @(posedge Clk) begin
    if (rom_rd) p1 <= mem[rom_addr];
    p2 <= p1;
  end
  assign rom_q = p2;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { logic [SW-1:0] s; int lat; } exp_t;
  exp_t        exp_q[$];
  int unsigned addr_q[$];
  int total = 0, bad = 0;
  int do_cyc = 0, nvalid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  always @(negedge Clk) begin
    check("init_high", {31'd0, INIT}, 32'd1);
    if (rom_rd) begin
      if (addr_q.size() == 0) fail("unexpected_rom_rd", {15'd0, rom_addr});
      else check("rom_addr", {15'd0, rom_addr}, addr_q.pop_front());
    end
    if (sample_valid) begin
      nvalid++;
      if (exp_q.size() == 0) fail("unexpected_sample", {16'd0, sample_out});
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample_out", {16'd0, sample_out}, {16'd0, e.s});
        check("latency", cyc - do_cyc, e.lat);
      end
    end
  end

  // One codec request; optional trigger pulse in the cycle just before data_over.
  task automatic send(input logic [SW-1:0] s, input int lat, input int ba, input int sa,
                      input logic [NS-1:0] tv);
    int n0, k;
    exp_q.push_back('{s, lat});
    addr_q.push_back(ba);
    if (sa >= 0) addr_q.push_back(sa);
    n0 = nvalid;
    if (tv != '0) begin
      @(negedge Clk); sfx_trig = tv;
    end
    @(negedge Clk); sfx_trig = '0; data_over = 1'b1; do_cyc = cyc;
    @(negedge Clk); data_over = 1'b0;
    k = 0;
    while (nvalid == n0 && k < 30) begin @(negedge Clk); k++; end
    if (nvalid == n0) fail("sample_timeout", k);
    @(negedge Clk);
  endtask

  task automatic trig(input logic [NS-1:0] tv);
    @(negedge Clk); sfx_trig = tv;
    @(negedge Clk); sfx_trig = '0;
    @(negedge Clk);
  endtask

  initial begin
    int n0;
    Reset = 1'b1; INIT_FINISH = 1'b0; data_over = 1'b0; bgm_en = 1'b1; sfx_trig = '0;
    sfx_base = {17'd400, 17'd300, 17'd200, 17'd450};
    sfx_last = {17'd401, 17'd301, 17'd202, 17'd440};
    #1;
    check("rst_rom_rd", {31'd0, rom_rd}, 0);
    check("rst_rom_addr", {15'd0, rom_addr}, 0);
    check("rst_sample_out", {16'd0, sample_out}, 0);
    check("rst_sample_valid", {31'd0, sample_valid}, 0);
    check("rst_sfx_busy", {31'd0, sfx_busy}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Held in WAIT_INIT: no reads, triggers ignored.
    repeat (5) @(negedge Clk);
    sfx_trig = 4'b0001;
    @(negedge Clk); sfx_trig = '0;
    repeat (14) @(negedge Clk);
    INIT_FINISH = 1'b1;
    repeat (3) @(negedge Clk);
    check("pre_init_trig_ignored", {31'd0, sfx_busy}, 0);

    // BGM only, walking through the wrap 7 -> 0.
    for (int i = 0; i < 9; i++) begin
      mem[i % 8] = 16'h0010 + 16'(i);
      send(16'h0010 + 16'(i), 5, i % 8, -1, '0);
    end

    // Effect 1 (pending 0110 -> lowest index 1), words 200..202.
    trig(4'b0110);
    check("sfx_id_1", {30'd0, sfx_id}, 1);
    check("sfx_busy_on", {31'd0, sfx_busy}, 1);
    mem[1] = 16'h0100; mem[200] = 16'h0011; send(16'h0111, 8, 1, 200, '0);
    mem[2] = 16'h0200; mem[201] = 16'hFFFF; send(16'h01FF, 8, 2, 201, '0);
    check("sfx_busy_mid", {31'd0, sfx_busy}, 1);
    mem[3] = 16'h0300; mem[202] = 16'h0003; send(16'h0303, 8, 3, 202, '0);
    check("sfx_busy_end", {31'd0, sfx_busy}, 0);

    // Saturation both ways with effect 2.
    trig(4'b0100);
    check("sfx_id_2", {30'd0, sfx_id}, 2);
    mem[4] = 16'h7000; mem[300] = 16'h2000; send(16'h7FFF, 8, 4, 300, '0);
    mem[5] = 16'h9000; mem[301] = 16'hA000; send(16'h8000, 8, 5, 301, '0);

    // BGM muted: SFX word passes through and the BGM address holds.
    bgm_en = 1'b0;
    trig(4'b1000);
    check("sfx_id_3", {30'd0, sfx_id}, 3);
    mem[6] = 16'h1111; mem[400] = 16'h4321; send(16'h4321, 8, 6, 400, '0);
    mem[401] = 16'h8765; send(16'h8765, 8, 6, 401, '0);
    bgm_en = 1'b1;

    // Trigger pending together with data_over; degenerate range plays one word.
    mem[6] = 16'h0001; mem[450] = 16'h0002; send(16'h0003, 8, 6, 450, 4'b0001);
    check("sfx_id_0", {30'd0, sfx_id}, 0);
    check("degenerate_done", {31'd0, sfx_busy}, 0);
    mem[7] = 16'h0007; send(16'h0007, 5, 7, -1, '0);

    // Second data_over two cycles later is dropped and flags overrun.
    check("overrun_clear", {31'd0, overrun}, 0);
    mem[0] = 16'h0042;
    exp_q.push_back('{16'h0042, 5});
    addr_q.push_back(0);
    n0 = nvalid;
    @(negedge Clk); data_over = 1'b1; do_cyc = cyc;
    @(negedge Clk); data_over = 1'b0;
    @(negedge Clk); data_over = 1'b1;
    @(negedge Clk); data_over = 1'b0;
    repeat (15) @(negedge Clk);
    check("overrun_set", {31'd0, overrun}, 1);
    check("single_sample", nvalid - n0, 1);

    // Reset during WAIT_SFX: fetches abort, no sample emerges.
    trig(4'b0010);
    addr_q.push_back(1);
    addr_q.push_back(200);
    @(negedge Clk); data_over = 1'b1;
    @(negedge Clk); data_over = 1'b0;
    repeat (4) @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("mid_rst_rom_rd", {31'd0, rom_rd}, 0);
    check("mid_rst_rom_addr", {15'd0, rom_addr}, 0);
    check("mid_rst_sample_out", {16'd0, sample_out}, 0);
    check("mid_rst_sample_valid", {31'd0, sample_valid}, 0);
    check("mid_rst_sfx_busy", {31'd0, sfx_busy}, 0);
    check("mid_rst_sfx_id", {30'd0, sfx_id}, 0);
    check("mid_rst_overrun", {31'd0, overrun}, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);

    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
